// File: rtl/gpu_tile_pkg.sv
// Shared definitions for the tile scheduler: tile geometry, the bit layout of
// a triangle setup record, and the scheduler state encoding.
package gpu_tile_pkg;

  // A tile is 32x32 pixels, so a tile index shifted by 5 gives its pixel origin.
  localparam int TILE_SHIFT = 5;

  // Triangle record field widths.
  localparam int A_W     = 19;
  localparam int B_W     = 24;
  localparam int W_W     = 32;
  localparam int Z_W     = 27;
  localparam int COLOR_W = 16;
  localparam int TRI_W   = 322;

  // Field LSB offsets; the record is packed MSB first starting with color,
  // so A01 sits at bit 0.
  localparam int OFF_A01   = 0;
  localparam int OFF_A12   = 19;
  localparam int OFF_A20   = 38;
  localparam int OFF_B01   = 57;
  localparam int OFF_B12   = 81;
  localparam int OFF_B20   = 105;
  localparam int OFF_W0    = 129;
  localparam int OFF_W1    = 161;
  localparam int OFF_W2    = 193;
  localparam int OFF_DZDX  = 225;
  localparam int OFF_DZDY  = 252;
  localparam int OFF_ZC    = 279;
  localparam int OFF_COLOR = 306;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_SETUP = 3'd3,
    ST_ISSUE = 3'd4,
    ST_WAIT  = 3'd5,
    ST_FLUSH = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  // Sign-extend an edge coefficient to the 32-bit edge-function width.
  function automatic logic [31:0] sext_a(input logic [A_W-1:0] v);
    return {{(32-A_W){v[A_W-1]}}, v};
  endfunction

  function automatic logic [31:0] sext_b(input logic [B_W-1:0] v);
    return {{(32-B_W){v[B_W-1]}}, v};
  endfunction

endpackage

// File: rtl/tile_origin_setup.sv
// Moves a triangle's edge values and depth from the screen origin to the
// current tile origin (x0,y0). One registered stage: load in, result next cycle.
// clr forces all outputs to zero (used for the clear pass).
module tile_origin_setup
  import gpu_tile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [9:0]       x0,
  input  logic [8:0]       y0,
  input  logic [A_W-1:0]   a01,
  input  logic [A_W-1:0]   a12,
  input  logic [A_W-1:0]   a20,
  input  logic [B_W-1:0]   b01,
  input  logic [B_W-1:0]   b12,
  input  logic [B_W-1:0]   b20,
  input  logic [W_W-1:0]   w0_in,
  input  logic [W_W-1:0]   w1_in,
  input  logic [W_W-1:0]   w2_in,
  input  logic [Z_W-1:0]   dzdx,
  input  logic [Z_W-1:0]   dzdy,
  input  logic [Z_W-1:0]   zc_in,
  output logic [W_W-1:0]   w0,
  output logic [W_W-1:0]   w1,
  output logic [W_W-1:0]   w2,
  output logic [Z_W-1:0]   zc
);

  logic [31:0] x_ext;
  logic [31:0] y_ext;
  logic [Z_W-1:0] x_z;
  logic [Z_W-1:0] y_z;

  assign x_ext = {22'd0, x0};
  assign y_ext = {23'd0, y0};
  assign x_z   = {17'd0, x0};
  assign y_z   = {18'd0, y0};

  // Low 32 bits of the products are exact modulo 2^32, so two's-complement
  // wrap falls out of plain unsigned arithmetic on sign-extended operands.
  function automatic logic [31:0] adj(input logic [31:0] w, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] x,
                                      input logic [31:0] y);
    return w + a * x + b * y;
  endfunction

  // Register the adjusted origin values; clear pass zeroes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
      zc <= '0;
    end else if (clr) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
      zc <= '0;
    end else if (load) begin
      w0 <= adj(w0_in, sext_a(a01), sext_b(b01), x_ext, y_ext);
      w1 <= adj(w1_in, sext_a(a12), sext_b(b12), x_ext, y_ext);
      w2 <= adj(w2_in, sext_a(a20), sext_b(b20), x_ext, y_ext);
      zc <= zc_in + dzdx * x_z + dzdy * y_z;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Frame-level tile sequencer: walks tiles in raster order, runs a clear pass
// and then every triangle through the tile renderer, then hands each finished
// tile to writeback.
// Optional build macro STATS_EN adds stat_cycles / stat_tris counters.
//
// Handshakes: tr_start is a one-cycle command pulse; the renderer reports
// completion by holding tr_done high, which is ignored for START_GUARD cycles
// after each start. flush_req is a valid that stays high until a cycle where
// flush_ack (ready) is also high; that cycle is the transfer, and ack may be
// high in the very first cycle of the request.
module tile_scheduler
  import gpu_tile_pkg::*;
#(
  parameter int TILES_X     = 20,
  parameter int TILES_Y     = 15,
  parameter int TRI_AW      = 10,
  parameter int START_GUARD = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [TRI_AW:0]     num_tris,
  output logic                busy,
  output logic                frame_done,
  output logic [TRI_AW-1:0]   tri_addr,
  output logic                tri_rd,
  input  logic [TRI_W-1:0]    tri_data,
  output logic                tr_start,
  output logic                tr_clear,
  output logic [A_W-1:0]      tr_A01,
  output logic [A_W-1:0]      tr_A12,
  output logic [A_W-1:0]      tr_A20,
  output logic [B_W-1:0]      tr_B01,
  output logic [B_W-1:0]      tr_B12,
  output logic [B_W-1:0]      tr_B20,
  output logic [W_W-1:0]      tr_w0,
  output logic [W_W-1:0]      tr_w1,
  output logic [W_W-1:0]      tr_w2,
  output logic [Z_W-1:0]      tr_dzdx,
  output logic [Z_W-1:0]      tr_dzdy,
  output logic [Z_W-1:0]      tr_zC,
  output logic [COLOR_W-1:0]  tr_color,
  input  logic                tr_done,
  output logic                flush_req,
  input  logic                flush_ack,
  output logic [4:0]          tile_x,
  output logic [3:0]          tile_y,
`ifdef STATS_EN
  output logic [31:0]         stat_cycles,
  output logic [31:0]         stat_tris,
`endif
  output state_t              fsm_state
);

  localparam int GW = (START_GUARD < 1) ? 1 : $clog2(START_GUARD + 1);

  state_t            state_q, state_d;
  logic [4:0]        tile_x_q;
  logic [3:0]        tile_y_q;
  logic [TRI_AW:0]   tri_idx_q;
  logic [TRI_AW:0]   num_q;
  logic [GW-1:0]     guard_q;
  logic              clear_q;
  logic              accept;
  logic              flush_done;
  logic              last_tile;
  logic              last_col;
  logic              enter_clear;
  logic              load_rec;
  logic [9:0]        x0;
  logic [8:0]        y0;

  assign accept      = (state_q == ST_IDLE) && frame_start;
  assign flush_done  = (state_q == ST_FLUSH) && flush_ack;
  assign last_col    = (tile_x_q == 5'(TILES_X - 1));
  assign last_tile   = last_col && (tile_y_q == 4'(TILES_Y - 1));
  assign enter_clear = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
  assign load_rec    = (state_q == ST_SETUP);
  assign x0          = 10'(tile_x_q) << TILE_SHIFT;
  assign y0          = 9'(tile_y_q) << TILE_SHIFT;

  assign tile_x    = tile_x_q;
  assign tile_y    = tile_y_q;
  assign tr_clear  = clear_q;
  assign fsm_state = state_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and strobe outputs.
  always_comb begin
    state_d    = state_q;
    tr_start   = 1'b0;
    tri_rd     = 1'b0;
    tri_addr   = '0;
    flush_req  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        tr_start = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_FETCH: begin
        if (tri_idx_q == num_q) begin
          state_d = ST_FLUSH;
        end else begin
          tri_rd   = 1'b1;
          tri_addr = tri_idx_q[TRI_AW-1:0];
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ISSUE;
      ST_ISSUE: begin
        tr_start = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT:  if (guard_q == GW'(START_GUARD) && tr_done) state_d = ST_FETCH;
      ST_FLUSH: begin
        flush_req = 1'b1;
        if (flush_ack) state_d = last_tile ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Tile position, triangle index, latched count and start guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_x_q  <= '0;
      tile_y_q  <= '0;
      tri_idx_q <= '0;
      num_q     <= '0;
      guard_q   <= '0;
    end else begin
      if (accept) begin
        num_q     <= num_tris;
        tile_x_q  <= '0;
        tile_y_q  <= '0;
        tri_idx_q <= '0;
      end else if (flush_done) begin
        tri_idx_q <= '0;
        if (last_tile) begin
          tile_x_q <= '0;
          tile_y_q <= '0;
        end else if (last_col) begin
          tile_x_q <= '0;
          tile_y_q <= tile_y_q + 4'd1;
        end else begin
          tile_x_q <= tile_x_q + 5'd1;
        end
      end else if (state_q == ST_ISSUE) begin
        tri_idx_q <= tri_idx_q + 1'b1;
      end
      if (state_q != ST_WAIT)                guard_q <= '0;
      else if (guard_q != GW'(START_GUARD))  guard_q <= guard_q + 1'b1;
    end
  end

  // Pass-through renderer fields: zeroed for the clear pass, loaded from the
  // triangle record on the data cycle, then held through the render.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_q  <= 1'b0;
      tr_A01   <= '0;
      tr_A12   <= '0;
      tr_A20   <= '0;
      tr_B01   <= '0;
      tr_B12   <= '0;
      tr_B20   <= '0;
      tr_dzdx  <= '0;
      tr_dzdy  <= '0;
      tr_color <= '0;
    end else if (enter_clear) begin
      clear_q  <= 1'b1;
      tr_A01   <= '0;
      tr_A12   <= '0;
      tr_A20   <= '0;
      tr_B01   <= '0;
      tr_B12   <= '0;
      tr_B20   <= '0;
      tr_dzdx  <= '0;
      tr_dzdy  <= '0;
      tr_color <= '0;
    end else if (load_rec) begin
      clear_q  <= 1'b0;
      tr_A01   <= tri_data[OFF_A01 +: A_W];
      tr_A12   <= tri_data[OFF_A12 +: A_W];
      tr_A20   <= tri_data[OFF_A20 +: A_W];
      tr_B01   <= tri_data[OFF_B01 +: B_W];
      tr_B12   <= tri_data[OFF_B12 +: B_W];
      tr_B20   <= tri_data[OFF_B20 +: B_W];
      tr_dzdx  <= tri_data[OFF_DZDX +: Z_W];
      tr_dzdy  <= tri_data[OFF_DZDY +: Z_W];
      tr_color <= tri_data[OFF_COLOR +: COLOR_W];
    end
  end

  tile_origin_setup u_origin (
    .clk   (clk),
    .rst   (rst),
    .clr   (enter_clear),
    .load  (load_rec),
    .x0    (x0),
    .y0    (y0),
    .a01   (tri_data[OFF_A01 +: A_W]),
    .a12   (tri_data[OFF_A12 +: A_W]),
    .a20   (tri_data[OFF_A20 +: A_W]),
    .b01   (tri_data[OFF_B01 +: B_W]),
    .b12   (tri_data[OFF_B12 +: B_W]),
    .b20   (tri_data[OFF_B20 +: B_W]),
    .w0_in (tri_data[OFF_W0 +: W_W]),
    .w1_in (tri_data[OFF_W1 +: W_W]),
    .w2_in (tri_data[OFF_W2 +: W_W]),
    .dzdx  (tri_data[OFF_DZDX +: Z_W]),
    .dzdy  (tri_data[OFF_DZDY +: Z_W]),
    .zc_in (tri_data[OFF_ZC +: Z_W]),
    .w0    (tr_w0),
    .w1    (tr_w1),
    .w2    (tr_w2),
    .zc    (tr_zC)
  );

`ifdef STATS_EN
  // Saturating frame statistics, restarted by each accepted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cycles <= '0;
      stat_tris   <= '0;
    end else if (accept) begin
      stat_cycles <= '0;
      stat_tris   <= '0;
    end else begin
      if (busy && stat_cycles != '1)                  stat_cycles <= stat_cycles + 32'd1;
      if (state_q == ST_ISSUE && stat_tris != '1)     stat_tris   <= stat_tris + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler on a 2x2 tile grid.
module tb_tile_scheduler;
  import gpu_tile_pkg::*;

  localparam int TX = 2;
  localparam int TY = 2;
  localparam int AW = 10;
  localparam int SG = 3;

  logic               clk;
  logic               rst;
  logic               frame_start;
  logic [AW:0]        num_tris;
  logic               busy;
  logic               frame_done;
  logic [AW-1:0]      tri_addr;
  logic               tri_rd;
  logic [TRI_W-1:0]   tri_data;
  logic               tr_start;
  logic               tr_clear;
  logic [18:0]        tr_A01, tr_A12, tr_A20;
  logic [23:0]        tr_B01, tr_B12, tr_B20;
  logic [31:0]        tr_w0, tr_w1, tr_w2;
  logic [26:0]        tr_dzdx, tr_dzdy, tr_zC;
  logic [15:0]        tr_color;
  logic               tr_done;
  logic               flush_req;
  logic               flush_ack;
  logic [4:0]         tile_x;
  logic [3:0]         tile_y;
`ifdef STATS_EN
  logic [31:0]        stat_cycles;
  logic [31:0]        stat_tris;
`endif
  state_t             fsm_state;

  tile_scheduler #(.TILES_X(TX), .TILES_Y(TY), .TRI_AW(AW), .START_GUARD(SG)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .num_tris(num_tris),
    .busy(busy), .frame_done(frame_done), .tri_addr(tri_addr), .tri_rd(tri_rd),
    .tri_data(tri_data), .tr_start(tr_start), .tr_clear(tr_clear),
    .tr_A01(tr_A01), .tr_A12(tr_A12), .tr_A20(tr_A20),
    .tr_B01(tr_B01), .tr_B12(tr_B12), .tr_B20(tr_B20),
    .tr_w0(tr_w0), .tr_w1(tr_w1), .tr_w2(tr_w2),
    .tr_dzdx(tr_dzdx), .tr_dzdy(tr_dzdy), .tr_zC(tr_zC), .tr_color(tr_color),
    .tr_done(tr_done), .flush_req(flush_req), .flush_ack(flush_ack),
    .tile_x(tile_x), .tile_y(tile_y),
`ifdef STATS_EN
    .stat_cycles(stat_cycles), .stat_tris(stat_tris),
`endif
    .fsm_state(fsm_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected {w0, w1, 5'b0, zC} per triangle start, in issue order.
  logic [95:0] exp_q[$];
  logic [95:0] got_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Event monitor, sampled on the falling edge.
  int cyc = 0, start_cnt = 0, clear_start_cnt = 0, rd_cnt = 0;
  int flush_rise = 0, done_cnt = 0, bad_addr = 0;
  int last_start = -1, min_sp = 1000;
  logic flush_prev = 1'b0;
  logic [18:0] last_a12 = '0;
  logic [15:0] last_color = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      flush_prev = 1'b0;
    end else begin
      if (tr_start) begin
        if (last_start >= 0 && (cyc - last_start) < min_sp) min_sp = cyc - last_start;
        last_start = cyc;
        start_cnt++;
        if (tr_clear) clear_start_cnt++;
        else begin
          got_q.push_back({tr_w0, tr_w1, 5'b0, tr_zC});
          last_a12   = tr_A12;
          last_color = tr_color;
        end
      end
      if (tri_rd) begin
        rd_cnt++;
        if (tri_addr != '0) bad_addr++;
      end
      if (flush_req && !flush_prev) flush_rise++;
      flush_prev = flush_req;
      if (frame_done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n);
    num_tris    = (AW+1)'(n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic clear_counts();
    start_cnt = 0; clear_start_cnt = 0; rd_cnt = 0; flush_rise = 0;
    done_cnt = 0; bad_addr = 0; last_start = -1; min_sp = 1000;
    got_q.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 96'(seen), 96'd1);
    repeat (4) tick();
    check({tag, "_done_pulses"}, 96'(done_cnt - d0), 96'd1);
    check({tag, "_busy_after"}, 96'(busy), 96'd0);
  endtask

  task automatic compare_queue(input string tag);
    logic [95:0] e, g;
    check({tag, "_issue_count"}, 96'(got_q.size()), 96'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '0;
      check({tag, "_origin"}, g, e);
    end
  endtask

  function automatic logic [TRI_W-1:0] mk_rec(
    input logic [15:0] color, input logic [26:0] zc, input logic [26:0] dzdy,
    input logic [26:0] dzdx, input logic [31:0] w1, input logic [31:0] w0,
    input logic [23:0] b01, input logic [18:0] a12, input logic [18:0] a01);
    return {color, zc, dzdy, dzdx, 32'd0, w1, w0, 24'd0, 24'd0, b01, 19'd0, a12, a01};
  endfunction

  initial begin
    int tx0, sc0, df0, fr0;
    bit dropped, moved;
    bit seen;

    rst = 1'b1; frame_start = 1'b0; num_tris = '0; tri_data = '0;
    tr_done = 1'b1; flush_ack = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_tr_start", 96'(tr_start), 96'd0);
    check("rst_flush_req", 96'(flush_req), 96'd0);
    check("rst_tri_rd", 96'(tri_rd), 96'd0);
    check("rst_tile", 96'({tile_x, tile_y}), 96'd0);
    check("rst_tr_w0", 96'(tr_w0), 96'd0);
    rst = 1'b0;
    tick();

    // Empty triangle list: every tile cleared and flushed, nothing read.
    clear_counts();
    start_frame(0);
    check("empty_busy", 96'(busy), 96'd1);
    wait_done("empty", 500);
    check("empty_starts", 96'(start_cnt), 96'(TX * TY));
    check("empty_clear_starts", 96'(clear_start_cnt), 96'(TX * TY));
    check("empty_tri_rd", 96'(rd_cnt), 96'd0);
    check("empty_flushes", 96'(flush_rise), 96'(TX * TY));

    // One triangle, A01=1, B01=2, w0=100: w0 moves by 32 per column, 64 per row.
    clear_counts();
    tri_data = mk_rec(16'h0, 27'h0, 27'h0, 27'h0, 32'd0, 32'd100, 24'd2, 19'd0, 19'd1);
    exp_q.push_back({32'd100, 32'd0, 5'b0, 27'd0});
    exp_q.push_back({32'd132, 32'd0, 5'b0, 27'd0});
    exp_q.push_back({32'd164, 32'd0, 5'b0, 27'd0});
    exp_q.push_back({32'd196, 32'd0, 5'b0, 27'd0});
    start_frame(1);
    wait_done("w0", 1000);
    compare_queue("w0");
    check("w0_tri_rd", 96'(rd_cnt), 96'd4);
    check("w0_tri_addr", 96'(bad_addr), 96'd0);
    check("w0_starts", 96'(start_cnt), 96'd8);
    check("w0_start_spacing", 96'(min_sp >= SG + 2), 96'd1);

    // Depth wraps mod 2^27 and a negative A12 wraps w1 below zero.
    clear_counts();
    tri_data = mk_rec(16'hBEEF, 27'h7FFFFFF, 27'd2, 27'd1, 32'd5, 32'd0, 24'd0,
                      19'h7FFFF, 19'd0);
    exp_q.push_back({32'd0, 32'd5,          5'b0, 27'h7FFFFFF});
    exp_q.push_back({32'd0, 32'hFFFFFFE5,   5'b0, 27'd31});
    exp_q.push_back({32'd0, 32'd5,          5'b0, 27'd63});
    exp_q.push_back({32'd0, 32'hFFFFFFE5,   5'b0, 27'd95});
    start_frame(1);
    wait_done("zc", 1000);
    compare_queue("zc");
    check("zc_pass_a12", 96'(last_a12), 96'h7FFFF);
    check("zc_pass_color", 96'(last_color), 96'hBEEF);

    // Writeback stall: request held, tile frozen, no new start, frame_start ignored.
    clear_counts();
    flush_ack = 1'b0;
    start_frame(0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (flush_req) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("stall_flush_seen", 96'(seen), 96'd1);
    tx0 = int'(tile_x);
    sc0 = start_cnt;
    dropped = 1'b0;
    moved = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!flush_req) dropped = 1'b1;
      if (int'(tile_x) != tx0) moved = 1'b1;
      tick();
    end
    check("stall_req_dropped", 96'(dropped), 96'd0);
    check("stall_tile_moved", 96'(moved), 96'd0);
    check("stall_no_start", 96'(start_cnt - sc0), 96'd0);
    flush_ack = 1'b1;
    wait_done("stall", 500);
    check("stall_flushes", 96'(flush_rise), 96'(TX * TY));

    // Reset while waiting on the renderer in tile (1,0).
    clear_counts();
    tri_data = mk_rec(16'h0, 27'h0, 27'h0, 27'h0, 32'd0, 32'd100, 24'd2, 19'd0, 19'd1);
    start_frame(1);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tile_x == 5'd1 && fsm_state == ST_WAIT && !tr_clear) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("rstmid_reached", 96'(seen), 96'd1);
    check("rstmid_w0_before", 96'(tr_w0), 96'd132);
    df0 = done_cnt;
    fr0 = flush_rise;
    rst = 1'b1;
    #1;
    check("rstmid_busy", 96'(busy), 96'd0);
    check("rstmid_state", 96'(fsm_state), 96'(ST_IDLE));
    check("rstmid_outputs", 96'({tr_start, tr_clear, flush_req, frame_done, tri_rd}), 96'd0);
    check("rstmid_w0", 96'(tr_w0), 96'd0);
    check("rstmid_tile", 96'({tile_x, tile_y}), 96'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rstmid_no_done", 96'(done_cnt - df0), 96'd0);
    check("rstmid_no_flush", 96'(flush_rise - fr0), 96'd0);
    start_frame(0);
    check("restart_clear_start", 96'({tr_start, tr_clear}), 96'b11);
    check("restart_tile", 96'({tile_x, tile_y}), 96'd0);
    wait_done("restart", 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
- Frame-level controller that sequences one tile_renderer across the screen: walks tiles in raster order, issues a clear pass per tile, replays every triangle of the frame's triangle list with per-tile edge/depth offsets, then hands the finished tile to writeback.
- Sits between the triangle-setup memory, the tile_renderer, and the tile-to-framebuffer copy engine.

Parameters:
TILES_X, 20, tiles per row (tile = 32x32 px)
TILES_Y, 15, tile rows
TRI_AW, 10, triangle memory address width (max 2^TRI_AW triangles)
START_GUARD, 3, cycles after tr_start during which tr_done is ignored

Ports:
clk  in  1  clock
rst  in  1  reset
frame_start  in  1  one-cycle pulse; begin a frame
num_tris  in  TRI_AW+1  triangle count, sampled on frame_start
busy  out  1  high from accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse after last tile flushed
tri_addr  out  TRI_AW  triangle memory read address
tri_rd  out  1  read strobe; data valid exactly 1 cycle later
tri_data  in  322  packed {color[15:0], zC, dzdy, dzdx [26:0 each], w2, w1, w0 [31:0], B20, B12, B01 [23:0], A20, A12, A01 [18:0]}; MSB first
tr_start  out  1  tile_renderer start pulse
tr_clear  out  1  clear_in to renderer
tr_A01/A12/A20  out  19  edge X coefficients (pass-through)
tr_B01/B12/B20  out  24  edge Y coefficients (pass-through)
tr_w0/w1/w2  out  32  edge values at tile origin
tr_dzdx/tr_dzdy  out  27  depth gradients (pass-through)
tr_zC  out  27  depth at tile origin
tr_color  out  16  triangle colour
tr_done  in  1  renderer done (high when idle)
flush_req  out  1  tile ready for writeback; held until ack
flush_ack  in  1  writeback accepted tile
tile_x  out  5  current tile column
tile_y  out  4  current tile row

Behaviour:
- Reset (rst async, active-high, clk rising edge): state IDLE; all outputs 0; tile_x=tile_y=0; counters 0.
- IDLE: frame_start -> latch num_tris, tile 0,0, busy=1, go CLEAR. frame_start ignored in all other states.
- CLEAR: all tr_* data 0, tr_clear=1, tr_start=1 for one cycle -> WAIT (return target FETCH).
- FETCH: if tri_idx==num_tris -> FLUSH; else tri_addr=tri_idx, tri_rd=1 one cycle -> SETUP.
- SETUP (data cycle): x0=tile_x*32, y0=tile_y*32; w_k = w_k + A_k*x0 + B_k*y0, 32-bit two's-complement wrap; zC = zC + dzdx*x0 + dzdy*y0 mod 2^27 (unsigned); register all tr_* fields -> ISSUE.
- ISSUE: tr_clear=0, tr_start=1 one cycle, tri_idx++ -> WAIT (return target FETCH).
- WAIT: guard counter START_GUARD cycles, tr_done not sampled; then wait for tr_done=1 -> return target. tr_* fields held stable from start until leaving WAIT.
- FLUSH: flush_req=1 until flush_ack sampled high (ack same cycle as req assert legal); then tri_idx=0, advance tile: tile_x++ ; at TILES_X-1 wrap to 0 and tile_y++; after tile (TILES_X-1,TILES_Y-1) -> DONE, else CLEAR.
- DONE: frame_done=1 one cycle, busy=0 -> IDLE.
- num_tris=0: every tile cleared and flushed, no tri_rd issued.
- tr_start never asserted twice without an intervening accepted tr_done.
- Reset mid-frame: immediate return to IDLE, no flush_req, no frame_done.

Optional Feature:
- STATS_EN defined: adds outputs stat_cycles (32, clocks while busy) and stat_tris (32, ISSUE count); both cleared on accepted frame_start, saturate at all-ones.
- Undefined: ports and counters absent.

Decomposition:
- Package gpu_tile_pkg: TILE_SHIFT=5, tri_data field offsets/widths, state enum encoding.
- Sub-module tile_origin_setup: registered edge/depth origin adjust (x0,y0 plus record in, adjusted w0-2/zC out, 1-cycle).

Test Plan:
- TILES 2x1, num_tris=0, ack immediate -> 2 clear starts, 2 flush_req, frame_done 1 pulse, no tri_rd.
- TILES 2x2, 1 triangle A01=1,B01=2,w0=100 -> tr_w0 = 100,132,164,196 for tiles (0,0),(1,0),(0,1),(1,1).
- zC=0x7FFFFFF, dzdx=1, tile(1,0) -> tr_zC=31 (wrap mod 2^27).
- tr_done held high continuously -> tr_start spacing ≥ START_GUARD+2 cycles; no double start.
- flush_ack held low 50 cycles -> flush_req stays high, tile_x unchanged, no tr_start.
- rst pulse during WAIT of tile 1 -> busy=0, all outputs 0; new frame_start restarts at tile 0,0.
